// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock-enable generator.
// Each channel divides clk by its own run-time divisor and emits a one-cycle tick plus a square wave.
module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 5,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] out,
  output logic [WIDTH-1:0]    rd_div
);

  logic [WIDTH-1:0] div_arr [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic             mode_q;
    logic             tick_q;
    logic             out_q;
    logic             cfg_hit;
    logic             at_last;

    assign cfg_hit = cfg_we && (int'(cfg_ch) == i);

    // A divisor of 0 runs like a divisor of 1, so its terminal count is 0
    assign at_last = (div_q == '0) ? (cnt_q == '0) : (cnt_q == div_q - WIDTH'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= WIDTH'(DEFAULT_DIV);
        mode_q <= 1'b1;
        tick_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        if (cfg_hit) begin
          div_q  <= cfg_div;
          mode_q <= cfg_mode;
        end
        // A write or sync restarts the channel from a clean phase; the new rate counts next cycle
        if (cfg_hit || sync) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          out_q  <= 1'b0;
        end else if (ch_en[i]) begin
          if (at_last) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            out_q  <= mode_q ? ~out_q : 1'b0;
          end else begin
            cnt_q  <= cnt_q + WIDTH'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[i]    = tick_q;
    assign out[i]     = out_q;
    assign div_arr[i] = div_q;
  end

  always_comb begin
    rd_div = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(cfg_ch) == i) rd_div = div_arr[i];
    end
  end

endmodule
